// File: rtl/nyq_dec_pkg.sv
// NYQ decimator shared package.
// Register map, FSM encoding, limits and config bundle.
package nyq_dec_pkg;

    localparam int REG_FACT  = 0;
    localparam int REG_SHIFT = 1;
    localparam int REG_EN    = 2;

    localparam int D_MAX   = 16;
    localparam int FACT_W  = $clog2(D_MAX);
    localparam int SHIFT_W = 3;

    localparam logic [SHIFT_W-1:0] SHIFT_MAX = 3'd4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [FACT_W-1:0]  fact;
        logic [SHIFT_W-1:0] shift;
        logic               en;
    } dec_cfg_t;

    function automatic logic [SHIFT_W-1:0] clamp_shift(
        input logic [SHIFT_W-1:0] s
    );
        return (s > SHIFT_MAX) ? SHIFT_MAX : s;
    endfunction

endpackage

// File: rtl/nyq_dec_sat.sv
// NYQ decimator output stage.
// Round-half-up arithmetic shift, then clip to output width.
module nyq_dec_sat
    import nyq_dec_pkg::*;
#(
    parameter int ACC_WIDTH = 28,
    parameter int OUT_WIDTH = 24
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    input  logic        [SHIFT_W-1:0]   shift,
    output logic signed [OUT_WIDTH-1:0] res
);

    localparam int EW = ACC_WIDTH + 1;

    localparam logic signed [EW-1:0] MAX_V =
        {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V =
        {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] rsum;
    logic signed [EW-1:0] shifted;

    // One guard bit keeps the rounding add from wrapping.
    assign ext     = {sum[ACC_WIDTH-1], sum};
    assign rnd     = (EW'(1) << shift) >> 1;
    assign rsum    = ext + rnd;
    assign shifted = rsum >>> shift;

    // Clip the scaled value into the signed output range.
    always_comb begin
        res = shifted[OUT_WIDTH-1:0];
        if (shifted > MAX_V) begin
            res = MAX_V[OUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            res = MIN_V[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/nyq_dec.sv
// NYQ decimator: integrate-and-dump over D samples,
// then round, scale and saturate the group sum.
module nyq_dec
    import nyq_dec_pkg::*;
#(
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int ADDR_WIDTH = 6,
    parameter int ACC_WIDTH  = IN_WIDTH + 4
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic                         WrEn_SI,
    input  logic        [ADDR_WIDTH-1:0] Addr_DI,
    input  logic        [23:0]           PAR_In_DI,
    input  logic signed [IN_WIDTH-1:0]   DEC_In_DI,
    input  logic                         DEC_InValid_SI,
    output logic signed [OUT_WIDTH-1:0]  DEC_Out_DO,
    output logic                         DEC_Valid_DO
);

    dec_cfg_t cfg;
    logic [0:0] state;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic        [FACT_W-1:0]    cnt;

    logic hit_fact;
    logic hit_shift;
    logic hit_en;
    logic cfg_hit;
    logic running;
    logic accept;
    logic dump;

    logic signed [OUT_WIDTH-1:0] sat_out;

    logic unused_par;
    assign unused_par = ^PAR_In_DI[23:FACT_W];

    assign hit_fact  = Addr_DI == ADDR_WIDTH'(REG_FACT);
    assign hit_shift = Addr_DI == ADDR_WIDTH'(REG_SHIFT);
    assign hit_en    = Addr_DI == ADDR_WIDTH'(REG_EN);
    assign cfg_hit   = WrEn_SI && (hit_fact || hit_shift || hit_en);

    assign running = (state == ST_RUN) && cfg.en;
    assign accept  = running && DEC_InValid_SI && !cfg_hit;
    assign dump    = accept && (cnt == cfg.fact);

    assign sample_ext = {
        {(ACC_WIDTH-IN_WIDTH){DEC_In_DI[IN_WIDTH-1]}},
        DEC_In_DI
    };
    assign sum = acc + sample_ext;

    // Config register file; writes land on the strobe edge.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            cfg <= '0;
        end else if (WrEn_SI) begin
            unique case (1'b1)
                hit_fact:  cfg.fact  <= PAR_In_DI[FACT_W-1:0];
                hit_shift: cfg.shift <= clamp_shift(PAR_In_DI[SHIFT_W-1:0]);
                hit_en:    cfg.en    <= PAR_In_DI[0];
                default:   ;
            endcase
        end
    end

    // IDLE/RUN control follows the enable register.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (cfg.en)  state <= ST_RUN;
                ST_RUN:  if (!cfg.en) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Accumulate accepted samples; a config write restarts the group.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI || !running || cfg_hit) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (dump) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + FACT_W'(1);
            end
        end
    end

    nyq_dec_sat #(
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_sat (
        .sum  (sum),
        .shift(cfg.shift),
        .res  (sat_out)
    );

    // Register the dumped group result and its strobe.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            DEC_Out_DO   <= '0;
            DEC_Valid_DO <= 1'b0;
        end else begin
            DEC_Valid_DO <= dump;
            if (dump) begin
                DEC_Out_DO <= sat_out;
            end
        end
    end

endmodule

// File: doc/nyq_dec.md
NYQ_DEC -- requirements
Module: nyq_dec

Interface
REQ-001 Parameter IN_WIDTH, default 24: signed sample width of DEC_In_DI.
REQ-002 Parameter OUT_WIDTH, default 24: signed sample width of DEC_Out_DO.
REQ-003 Parameter ADDR_WIDTH, default 6: width of Addr_DI.
REQ-004 Parameter ACC_WIDTH, default IN_WIDTH+4: signed accumulator width.
REQ-005 Clk_CI  in  1: single clock; all logic on rising edge.
REQ-006 Rst_RBI  in  1: reset, synchronous, active-low.
REQ-007 WrEn_SI  in  1: config write strobe, already decoded for this block.
REQ-008 Addr_DI  in  ADDR_WIDTH: config register address.
REQ-009 PAR_In_DI  in  24: config write data.
REQ-010 DEC_In_DI  in  IN_WIDTH: signed sample from the NYQ filter output.
REQ-011 DEC_InValid_SI  in  1: DEC_In_DI carries a sample this cycle.
REQ-012 DEC_Out_DO  out  OUT_WIDTH: signed decimated, scaled, saturated sample.
REQ-013 DEC_Valid_DO  out  1: one-cycle strobe marking a new DEC_Out_DO.

Function
REQ-014 Config registers: addr 0 FACT = PAR_In_DI[3:0] (decimation D = FACT+1, 1..16); addr 1 SHIFT = PAR_In_DI[2:0], values >4 clamp to 4; addr 2 EN = PAR_In_DI[0]; other addresses ignored.
REQ-015 Register write occurs on the clock edge where WrEn_SI=1; new value effective next cycle.
REQ-016 FSM states IDLE and RUN; IDLE->RUN when EN=1; RUN->IDLE when EN=0; in IDLE inputs ignored, accumulator and phase counter held at 0.
REQ-017 In RUN, a sample is accepted on each edge with DEC_InValid_SI=1; cycles with DEC_InValid_SI=0 leave accumulator and counter unchanged.
REQ-018 Phase counter counts accepted samples 0..FACT; on the edge accepting sample number FACT, sum = acc + sample is dumped, acc cleared, counter returns to 0.
REQ-019 Dump value: if SHIFT=0 then sum, else (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round-half-up); result saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-020 DEC_Out_DO and DEC_Valid_DO are registered: valid high exactly the cycle after the dump edge; DEC_Out_DO holds its last value between strobes.
REQ-021 Write to addr 0, 1 or 2 while in RUN clears accumulator and counter on the same edge; a sample arriving on that edge is discarded; no strobe is issued for the partial group.
REQ-022 Accumulator never overflows: ACC_WIDTH covers 16 full-scale samples.
REQ-023 D=1: every accepted sample produces a strobe one cycle later (pass-through with scaling/saturation).

Reset
REQ-024 On Rst_RBI=0 at an edge: FACT=0, SHIFT=0, EN=0, state IDLE, acc=0, counter=0, DEC_Out_DO=0, DEC_Valid_DO=0.
REQ-025 Reset asserted mid-group discards the partial group; no strobe follows reset release until a full group of D samples is accepted.

Structure
REQ-026 Register addresses (0,1,2), FSM state encoding, SHIFT clamp limit 4 and max D 16 live in the shared project package/header.
REQ-027 Rounding+saturation is one sub-module, nyq_dec_sat, combinational, parameterised on ACC_WIDTH/OUT_WIDTH.
REQ-028 Top-level integration feeds NYQ_Out_DO into DEC_In_DI with DEC_InValid_SI tied high unless gated.

Verification
REQ-029 D=4,SHIFT=2,EN=1, inputs 1,2,3,4 -> one strobe, DEC_Out_DO=3 (12>>2), valid one cycle after 4th sample edge.
REQ-030 D=16,SHIFT=0, sixteen samples of 8388607 -> DEC_Out_DO=8388607 (positive saturation); D=2,SHIFT=0, two samples -8388608 -> -8388608.
REQ-031 D=1,SHIFT=0, inputs 5,-7,0 -> strobes every cycle, outputs 5,-7,0 with one-cycle latency.
REQ-032 D=4, InValid pattern 1,0,1,0,1,1 with inputs 10,x,20,x,30,40 (SHIFT=2) -> single strobe, output 25.
REQ-033 D=4, two samples accepted, then write addr 1 -> no strobe; next 4 samples of 8 with SHIFT=2 -> output 8.
REQ-034 Reset pulsed after 3 of 4 samples -> all outputs 0, EN=0; no strobe until EN rewritten and 4 new samples accepted.
